// File: rtl/ddmtd_pkg.sv
// Shared definitions for the DDMTD lock controller: FSM state encoding and
// the default phase-error width.
package ddmtd_pkg;

  localparam int PHASE_W_DEF = 18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/ddmtd_lock_ctrl_if.sv
// Sample stream into the lock controller and its status/average outputs.
// master drives samples (DDMTD core side), slave is the lock controller.
interface ddmtd_lock_ctrl_if
  import ddmtd_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
);

  logic                      phase_valid;
  logic signed [PHASE_W-1:0] phase_err;
  logic                      avg_valid;
  logic signed [PHASE_W-1:0] avg_err;
  logic                      locked;
  logic                      lost;
  logic                      stall;
  logic [1:0]                state;

  modport master (
    output phase_valid, phase_err,
    input  avg_valid, avg_err, locked, lost, stall, state
  );

  modport slave (
    input  phase_valid, phase_err,
    output avg_valid, avg_err, locked, lost, stall, state
  );

endinterface

// File: rtl/ddmtd_avg.sv
// Windowed averager: sums 2^LOG2_AVG accepted samples and registers the
// floor-rounded mean; win_done/win_avg expose the completing window early.
module ddmtd_avg
  import ddmtd_pkg::*;
#(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int LOG2_AVG = 3
) (
  input  logic                      clk_sys,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      accept,
  input  logic signed [PHASE_W-1:0] sample,
  output logic                      win_done,
  output logic signed [PHASE_W-1:0] win_avg,
  output logic                      avg_valid,
  output logic signed [PHASE_W-1:0] avg_err
);

  // LOG2_AVG guard bits hold a full window of worst-case samples.
  localparam int ACC_W = PHASE_W + LOG2_AVG;

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_sum;
  logic        [LOG2_AVG-1:0] cnt_q;

  assign acc_sum  = acc_q + ACC_W'(sample);
  assign win_done = accept && (cnt_q == '1);
  assign win_avg  = PHASE_W'(acc_sum >>> LOG2_AVG);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_valid <= 1'b0;
      avg_err   <= '0;
    end else if (clear) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= win_done;
      if (win_done) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        avg_err <= win_avg;
      end else if (accept) begin
        acc_q <= acc_sum;
        cnt_q <= cnt_q + LOG2_AVG'(1);
      end
    end
  end

endmodule

// File: rtl/ddmtd_lock_ctrl.sv
// DDMTD lock controller: averages phase-error windows, declares/drops lock
// with hysteresis counters, and runs a watchdog on the sample stream.
module ddmtd_lock_ctrl
  import ddmtd_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int LOG2_AVG   = 3,
  parameter int LOCK_THR   = 64,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int TO_LOG2    = 12
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             enable,
  ddmtd_lock_ctrl_if.slave bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  // Expiry fires on the edge that would take the idle count to 2^TO_LOG2-1.
  localparam logic [TO_LOG2-1:0] IDLE_LAST = TO_LOG2'((2 ** TO_LOG2) - 2);

  state_e                    state_q, state_d;
  logic [GOOD_W-1:0]         good_q, good_d;
  logic [BAD_W-1:0]          bad_q, bad_d;
  logic [TO_LOG2-1:0]        idle_q, idle_d;
  logic                      stall_q, stall_d;
  logic                      lost_q, lost_d;
  logic                      active;
  logic                      accept;
  logic                      wd_fire;
  logic                      win_done;
  logic                      in_tol;
  logic signed [PHASE_W-1:0] win_avg;
  logic                      avg_valid;
  logic signed [PHASE_W-1:0] avg_err;
  logic signed [PHASE_W:0]   avg_ext;
  logic        [PHASE_W:0]   avg_mag;

  assign active = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
  assign accept = enable && bus.phase_valid && active;

  ddmtd_avg #(
    .PHASE_W  (PHASE_W),
    .LOG2_AVG (LOG2_AVG)
  ) u_avg (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .clear     (!enable || wd_fire),
    .accept    (accept),
    .sample    (bus.phase_err),
    .win_done  (win_done),
    .win_avg   (win_avg),
    .avg_valid (avg_valid),
    .avg_err   (avg_err)
  );

  // One extra bit so the most negative average has a representable magnitude.
  assign avg_ext = {win_avg[PHASE_W-1], win_avg};
  assign avg_mag = avg_ext[PHASE_W] ? -avg_ext : avg_ext;
  assign in_tol  = (avg_mag <= (PHASE_W + 1)'(LOCK_THR));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    idle_d  = idle_q;
    stall_d = stall_q;
    lost_d  = 1'b0;
    wd_fire = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      good_d  = '0;
      bad_d   = '0;
      idle_d  = '0;
      stall_d = 1'b0;
    end else if (!active) begin
      state_d = ST_ACQUIRE;
      good_d  = '0;
      bad_d   = '0;
      idle_d  = '0;
      stall_d = 1'b0;
    end else begin
      if (accept) begin
        idle_d  = '0;
        stall_d = 1'b0;
      end else if (idle_q == IDLE_LAST) begin
        wd_fire = 1'b1;
        idle_d  = '0;
        stall_d = 1'b1;
        good_d  = '0;
        bad_d   = '0;
        state_d = ST_ACQUIRE;
        lost_d  = (state_q == ST_LOCKED);
      end else begin
        idle_d = idle_q + TO_LOG2'(1);
      end

      // Lock decisions happen only on the edge that completes a window.
      if (win_done) begin
        if (state_q == ST_ACQUIRE) begin
          if (!in_tol) begin
            good_d = '0;
          end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end else begin
          if (in_tol) begin
            bad_d = '0;
          end else if (bad_q == BAD_W'(UNLOCK_CNT - 1)) begin
            state_d = ST_ACQUIRE;
            lost_d  = 1'b1;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            bad_d = bad_q + BAD_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= ST_IDLE;
      good_q  <= '0;
      bad_q   <= '0;
      idle_q  <= '0;
      stall_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      idle_q  <= idle_d;
      stall_q <= stall_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.avg_valid = avg_valid;
  assign bus.avg_err   = avg_err;
  assign bus.locked    = (state_q == ST_LOCKED);
  assign bus.lost      = lost_q;
  assign bus.stall     = stall_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_ddmtd_lock_ctrl.sv
// Bench for ddmtd_lock_ctrl: table of windows with a due-cycle scoreboard,
// plus directed watchdog, reset and enable sequences.
module tb_ddmtd_lock_ctrl;
  import ddmtd_pkg::*;

  localparam int PW = 18;

  typedef struct {
    int first;
    int rest;
    int gap;
    int avg;
    int st;
    int ls;
  } win_t;

  typedef struct {
    int         due;
    int         avg;
    logic [1:0] st;
    logic       ls;
  } exp_t;

  logic clk_sys;
  logic rst;
  logic enable;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lost_seen = 0;
  exp_t sb[$];
  win_t tbl[15];

  ddmtd_lock_ctrl_if #(.PHASE_W(PW)) bus ();

  ddmtd_lock_ctrl #(.PHASE_W(PW)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .enable  (enable),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input int v);
    bus.phase_valid = 1'b1;
    bus.phase_err   = PW'(v);
    step();
    bus.phase_valid = 1'b0;
  endtask

  task automatic expect_window(input int avg, input int st, input int ls);
    exp_t e;
    e.due = cyc + 1;
    e.avg = avg;
    e.st  = 2'(st);
    e.ls  = 1'(ls);
    sb.push_back(e);
  endtask

  task automatic run_window(input win_t w);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_window(w.avg, w.st, w.ls);
      send(i == 0 ? w.first : w.rest);
      if (i < 7) repeat (w.gap) step();
    end
  endtask

  function automatic win_t mk(input int first, input int rest, input int gap,
                              input int avg, input int st, input int ls);
    win_t w;
    w.first = first;
    w.rest  = rest;
    w.gap   = gap;
    w.avg   = avg;
    w.st    = st;
    w.ls    = ls;
    return w;
  endfunction

  // Scoreboard side: every avg_valid must match the oldest expectation on its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (bus.lost === 1'b1) lost_seen++;
      if (bus.avg_valid === 1'b1 || (sb.size() > 0 && sb[0].due <= cyc)) begin
        if (sb.size() == 0) begin
          check("avg_valid_unexpected", bus.avg_valid, 0);
        end else begin
          e = sb.pop_front();
          check("avg_valid_cycle", bus.avg_valid === 1'b1 ? cyc : -1, e.due);
          check("avg_err", bus.avg_err, e.avg);
          check("win_state", bus.state, e.st);
          check("win_locked", bus.locked, (e.st == 2) ? 1 : 0);
          check("win_lost", bus.lost, e.ls);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(10, 10, 0, 10, 1, 0);
    tbl[1]  = mk(-3, -3, 0, -3, 1, 0);
    tbl[2]  = mk(-1, 0, 1, -1, 1, 0);
    tbl[3]  = mk(-131072, -131072, 0, -131072, 1, 0);
    tbl[4]  = mk(64, 64, 0, 64, 1, 0);
    tbl[5]  = mk(64, 64, 1, 64, 1, 0);
    tbl[6]  = mk(64, 64, 0, 64, 1, 0);
    tbl[7]  = mk(64, 64, 2, 64, 2, 0);
    tbl[8]  = mk(65, 65, 0, 65, 2, 0);
    tbl[9]  = mk(65, 65, 1, 65, 1, 1);
    tbl[10] = mk(-65, -64, 0, -65, 1, 0);
    tbl[11] = mk(71, 64, 3, 64, 1, 0);
    tbl[12] = mk(-64, -64, 0, -64, 1, 0);
    tbl[13] = mk(5, -5, 1, -4, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 2, 0);

    rst             = 1'b1;
    enable          = 1'b0;
    bus.phase_valid = 1'b0;
    bus.phase_err   = '0;
    repeat (3) step();
    check("rst_state", bus.state, 0);
    check("rst_avg_valid", bus.avg_valid, 0);
    check("rst_avg_err", bus.avg_err, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_lost", bus.lost, 0);
    check("rst_stall", bus.stall, 0);

    rst = 1'b0;
    step();
    check("idle_while_disabled", bus.state, 0);
    enable = 1'b1;
    step();
    check("idle_to_acquire", bus.state, 1);

    for (int w = 0; w < 15; w++) run_window(tbl[w]);

    // Watchdog from LOCKED: fires on the 4095th sample-less edge, not before.
    repeat (4094) step();
    check("wd_no_stall_early", bus.stall, 0);
    check("wd_still_locked", bus.state, 2);
    step();
    check("wd_stall", bus.stall, 1);
    check("wd_state", bus.state, 1);
    check("wd_locked_drop", bus.locked, 0);
    check("wd_lost", bus.lost, 1);
    step();
    check("wd_lost_one_cycle", bus.lost, 0);
    check("wd_stall_sticky", bus.stall, 1);
    send(0);
    check("wd_stall_cleared", bus.stall, 0);
    for (int i = 1; i < 8; i++) begin
      if (i == 7) expect_window(0, 1, 0);
      send(0);
    end

    // A sample on the expiry edge wins over the watchdog and stays in the window.
    repeat (4094) step();
    send(2);
    check("wd_sample_wins_stall", bus.stall, 0);
    check("wd_sample_wins_state", bus.state, 1);
    for (int i = 1; i < 8; i++) begin
      if (i == 7) expect_window(2, 1, 0);
      send(2);
    end

    // Reset mid-window discards the partial sum.
    for (int i = 0; i < 5; i++) send(1000);
    rst = 1'b1;
    step();
    check("midrst_state", bus.state, 0);
    check("midrst_avg_err", bus.avg_err, 0);
    check("midrst_stall", bus.stall, 0);
    rst = 1'b0;
    step();
    check("midrst_reacquire", bus.state, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_window(8, 1, 0);
      send(8);
    end

    // enable low mid-window discards the partial sum; avg_err holds.
    for (int i = 0; i < 5; i++) send(500);
    enable = 1'b0;
    step();
    check("dis_state", bus.state, 0);
    check("dis_avg_err_held", bus.avg_err, 8);
    enable = 1'b1;
    step();
    check("dis_reacquire", bus.state, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_window(-16, 1, 0);
      send(-16);
    end

    // enable falls together with a window-completing sample.
    for (int i = 0; i < 7; i++) send(100);
    enable          = 1'b0;
    bus.phase_valid = 1'b1;
    bus.phase_err   = PW'(100);
    step();
    bus.phase_valid = 1'b0;
    check("drop8_state", bus.state, 0);
    check("drop8_no_valid", bus.avg_valid, 0);
    check("drop8_avg_err_held", bus.avg_err, -16);
    enable = 1'b1;
    step();
    check("drop8_reacquire", bus.state, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_window(3, 1, 0);
      send(3);
    end

    repeat (4) step();
    check("scoreboard_drained", sb.size(), 0);
    check("lost_pulse_total", lost_seen, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
